multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main controller for the MIPS core. It replaces the single-cycle control decoder and sequences one shared ALU, one unified instruction/data memory and the register file over 3–5 cycles per instruction. It reads `opcode` from the datapath's instruction register and drives every datapath enable and mux select from a Moore state machine. A `mem_ready` handshake stretches the memory states.

## Interface
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  6  IR[31:26]; valid from DECODE onward
- `mem_ready`  in  1  memory access completes this cycle
- `pc_write`  out  1  unconditional PC load
- `branch`  out  1  PC load if ALU zero (beq)
- `branch_ne`  out  1  PC load if ALU not zero (bne)
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  IR load
- `reg_dst`  out  1  write register: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write data: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU A operand: 0 = PC, 1 = A register
- `alu_src_b`  out  2  ALU B operand: 00 = B register, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- `alu_op`  out  3  000 add, 001 sub, 010 funct-decoded, 011 and, 100 or, 101 slt
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `sign`  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, slti 001010, j 000010.
- All outputs are decoded from the state only, with one exception: `ir_write` and `pc_write` in FETCH are ANDed with `mem_ready`. Any strobe not listed for a state is 0.

States and transitions:
- INIT: all outputs 0. Always → FETCH.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=add, `pc_src`=00, `ir_write`=`pc_write`=`mem_ready`.
  - `mem_ready`=1 → DECODE; otherwise stay.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=add, `sign`=1. Computes the branch target into ALUOut. Next state by opcode:
  - lw/sw → MEMADR; R-type → RTEXEC; beq/bne → BRANCH; addi/andi/ori/slti → IEXEC; j → JUMP.
  - Any other opcode → FETCH, with `illegal_op`=1 for this cycle.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=add, `sign`=1. lw → MEMRD, sw → MEMWR.
- MEMRD: `mem_read`=1, `iord`=1. Stays until `mem_ready`, then → MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. → FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Stays until `mem_ready`, then → FETCH.
- RTEXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010. → RTWB.
- RTWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. → FETCH.
- IEXEC: `alu_src_a`=1, `alu_src_b`=10.
  - addi: `alu_op`=add, `sign`=1. andi: `alu_op`=and, `sign`=0. ori: `alu_op`=or, `sign`=0. slti: `alu_op`=slt, `sign`=1.
  - → IWB.
- IWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Keeps IEXEC's `sign` and `alu_op`. → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=sub, `pc_src`=01. Asserts `branch` for beq, `branch_ne` for bne. → FETCH.
- JUMP: `pc_write`=1, `pc_src`=10. → FETCH.

## Timing
- Reset: the state register goes to INIT immediately on `rst`. Every output is 0 while `rst` is high and in the first cycle after release. This holds even if `rst` arrives mid-instruction, including during a pending `mem_ready` wait.
- First FETCH is the second rising edge after `rst` falls.
- Cycle counts with `mem_ready` tied high:
  - lw 5; sw, R-type and I-type ALU 4; beq, bne and j 3; illegal opcode 2.
- Each cycle with `mem_ready` low adds one cycle in FETCH, MEMRD or MEMWR. Strobes stay asserted and stable throughout the wait.
- `opcode` is sampled in every state after DECODE. The datapath must hold IR stable; `ir_write` is 0 outside FETCH, so it does.
- `mem_read` and `mem_write` are never both 1. `reg_write` and `mem_write` are never both 1.

## Structure
- Shared package `mips_pkg`:
  - opcode constants
  - `alu_op` codes
  - `alu_src_b` and `pc_src` encodings
  - state enum
- The datapath and ALU decoder import the same package.
- A single module: the state register plus a next-state/output `case` block. No sub-modules.

## Test plan
- Reset mid-MEMRD with `mem_ready` low: all outputs 0 while `rst` is high. FETCH (`mem_read`=1, `iord`=0) two edges after release.
- lw (opcode 100011), `mem_ready`=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB. Final cycle has `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next FETCH on cycle 6.
- sw with `mem_ready` low for 3 cycles in MEMWR: `mem_write`=1 and `iord`=1 held for 4 cycles. `reg_write` never asserted. FETCH follows.
- beq (000100) then bne (000101): in BRANCH, `alu_op`=001, `pc_src`=01, and `branch`/`branch_ne` respectively. Each instruction takes 3 cycles.
- ori (001101) then slti (001010): `sign`=0 with `alu_op`=100, then `sign`=1 with `alu_op`=101, held through IWB. `reg_dst`=0.
- Opcode 111111: `illegal_op` pulses exactly one cycle, in DECODE. FETCH follows with no `reg_write`, `mem_write` or `pc_write` beyond the fetch.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, ALU op codes,
// datapath mux selects and the controller state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTEXEC,
    S_RTWB,
    S_IEXEC,
    S_IWB,
    S_BRANCH,
    S_JUMP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       sign;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing
// the shared ALU, unified memory and register file.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       sign,
  output logic       illegal_op
);

  state_t state, state_n;
  logic   hold;
  ctrl_t  c;

  logic is_mem, is_rt, is_br, is_imm, is_j;
  logic [2:0] imm_alu;
  logic       imm_sign;

  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_rt  = (opcode == OP_RTYPE);
  assign is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI)
               || (opcode == OP_ORI)  || (opcode == OP_SLTI);
  assign is_j   = (opcode == OP_J);

  always_comb begin
    imm_alu  = ALU_ADD;
    imm_sign = 1'b1;
    unique case (opcode)
      OP_ANDI: begin imm_alu = ALU_AND; imm_sign = 1'b0; end
      OP_ORI:  begin imm_alu = ALU_OR;  imm_sign = 1'b0; end
      OP_SLTI: imm_alu = ALU_SLT;
      default: ;
    endcase
  end

  // hold keeps INIT for one full cycle after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      hold  <= 1'b1;
    end else begin
      state <= state_n;
      hold  <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_INIT:   state_n = hold ? S_INIT : S_FETCH;
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:  state_n = S_MEMADR;
          is_rt:   state_n = S_RTEXEC;
          is_br:   state_n = S_BRANCH;
          is_imm:  state_n = S_IEXEC;
          is_j:    state_n = S_JUMP;
          default: state_n = S_FETCH;
        endcase
      end
      S_MEMADR: state_n = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_n = S_FETCH;
      S_RTEXEC: state_n = S_RTWB;
      S_IEXEC:  state_n = S_IWB;
      S_MEMWB, S_RTWB, S_IWB,
      S_BRANCH, S_JUMP: state_n = S_FETCH;
      default:  state_n = S_INIT;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_b  = SRCB_IMM_SH;
        c.sign       = 1'b1;
        c.illegal_op = !(is_mem || is_rt || is_br
                         || is_imm || is_j);
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.sign      = 1'b1;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_RTEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_FUNCT;
      end
      S_RTWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = imm_alu;
        c.sign      = imm_sign;
      end
      S_IWB: begin
        c.reg_write = 1'b1;
        c.alu_op    = imm_alu;
        c.sign      = imm_sign;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PC_ALUOUT;
        c.branch    = (opcode == OP_BEQ);
        c.branch_ne = (opcode == OP_BNE);
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JUMP;
      end
      default: c = '0;
    endcase
  end

  assign pc_write   = c.pc_write;
  assign branch     = c.branch;
  assign branch_ne  = c.branch_ne;
  assign iord       = c.iord;
  assign mem_read   = c.mem_read;
  assign mem_write  = c.mem_write;
  assign ir_write   = c.ir_write;
  assign reg_dst    = c.reg_dst;
  assign mem_to_reg = c.mem_to_reg;
  assign reg_write  = c.reg_write;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign alu_op     = c.alu_op;
  assign pc_src     = c.pc_src;
  assign sign       = c.sign;
  assign illegal_op = c.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control
// against a per-instruction step-sequence model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch, branch_ne, iord;
  logic       mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       sign, illegal_op;

  int ntests = 0;
  int nfail  = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .mem_ready(mem_ready), .pc_write(pc_write),
    .branch(branch), .branch_ne(branch_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .sign(sign),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, branch, branch_ne, iord;
    logic       mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       sign, illegal_op;
  } ctl_t;

  typedef enum {
    P_F, P_D, P_MA, P_MR, P_MWB, P_MW,
    P_RX, P_RW, P_IX, P_IW, P_B, P_J
  } ph_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, JMP = 6'b000010;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010;

  ctl_t got;
  assign got = {pc_write, branch, branch_ne, iord,
                mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_src, sign, illegal_op};

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic ctl_t model(ph_t p, logic [5:0] op,
                                 logic mr);
    ctl_t e = '0;
    case (p)
      P_F: begin
        e.mem_read = 1; e.alu_src_b = 2'b01;
        e.ir_write = mr; e.pc_write = mr;
      end
      P_D: begin
        e.alu_src_b = 2'b11; e.sign = 1;
        e.illegal_op = !(op inside {RT, LW, SW, BEQ, BNE,
                         ADDI, ANDI, ORI, SLTI, JMP});
      end
      P_MA: begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10; e.sign = 1;
      end
      P_MR:  begin e.mem_read = 1; e.iord = 1; end
      P_MWB: begin e.reg_write = 1; e.mem_to_reg = 1; end
      P_MW:  begin e.mem_write = 1; e.iord = 1; end
      P_RX:  begin e.alu_src_a = 1; e.alu_op = 3'b010; end
      P_RW:  begin e.reg_write = 1; e.reg_dst = 1; end
      P_IX, P_IW: begin
        if (p == P_IX) begin
          e.alu_src_a = 1; e.alu_src_b = 2'b10;
        end else e.reg_write = 1;
        case (op)
          ANDI:    begin e.alu_op = 3'b011; e.sign = 0; end
          ORI:     begin e.alu_op = 3'b100; e.sign = 0; end
          SLTI:    begin e.alu_op = 3'b101; e.sign = 1; end
          default: begin e.alu_op = 3'b000; e.sign = 1; end
        endcase
      end
      P_B: begin
        e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_src = 2'b01;
        e.branch = (op == BEQ); e.branch_ne = (op == BNE);
      end
      P_J: begin e.pc_write = 1; e.pc_src = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic step(input ph_t p, input logic [5:0] op,
                      input logic mr);
    @(negedge clk);
    mem_ready = mr;
    opcode = (p == P_F) ? 6'($urandom) : op;
    #1 check(p.name(), 32'(got), 32'(model(p, op, mr)));
  endtask

  // mw_lows: low mem_ready cycles forced in MEMWR; rnd randomizes all waits
  task automatic run_instr(input logic [5:0] op,
                           input int mw_lows, input bit rnd);
    ph_t seq[$];
    seq = '{P_F, P_D};
    case (op)
      LW:  seq = {seq, P_MA, P_MR, P_MWB};
      SW:  seq = {seq, P_MA, P_MW};
      RT:  seq = {seq, P_RX, P_RW};
      BEQ, BNE: seq.push_back(P_B);
      ADDI, ANDI, ORI, SLTI: seq = {seq, P_IX, P_IW};
      JMP: seq.push_back(P_J);
      default: ;
    endcase
    foreach (seq[i]) begin
      bit waits = seq[i] inside {P_F, P_MR, P_MW};
      for (int k = 0; k < 8; k++) begin
        logic mr;
        if (rnd)
          mr = waits ? (k >= 3 || $urandom_range(0, 2) != 0)
                     : 1'($urandom);
        else
          mr = !(seq[i] == P_MW && k < mw_lows);
        step(seq[i], op, mr);
        if (!(waits && !mr)) break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    #1 check(tag, 32'(got), 32'd0);
  endtask

  logic [5:0] pool [10] = '{LW, SW, RT, BEQ, BNE,
                            ADDI, ANDI, ORI, SLTI, JMP};

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = '0;
    @(negedge clk); check_zero("rst_hold");
    @(negedge clk); rst = 1'b0; mem_ready = 1'b1;
    check_zero("rel_cycle0");
    @(negedge clk); check_zero("rel_cycle1");

    run_instr(LW, 0, 0);
    run_instr(SW, 3, 0);
    run_instr(BEQ, 0, 0);
    run_instr(BNE, 0, 0);
    run_instr(ORI, 0, 0);
    run_instr(SLTI, 0, 0);
    run_instr(6'b111111, 0, 0);

    // reset while MEMRD is stalled on mem_ready
    step(P_F, LW, 1);
    step(P_D, LW, 1);
    step(P_MA, LW, 1);
    step(P_MR, LW, 0);
    step(P_MR, LW, 0);
    @(negedge clk); rst = 1'b1; check_zero("rst_async");
    @(negedge clk); check_zero("rst_mid");
    @(negedge clk); rst = 1'b0; check_zero("rst_rel0");
    @(negedge clk); check_zero("rst_rel1");
    step(P_F, LW, 0);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int sel = $urandom_range(0, 11);
      op = (sel < 10) ? pool[sel] : 6'($urandom);
      run_instr(op, 0, 1);
    end
    step(P_F, LW, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
